// File: rtl/ball_pkg.sv
// Shared encodings for the ball engine: FSM states,
// direction polarities and bar-role selection.
package ball_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_MOVE  = 2'd2,
      ST_OVER  = 2'd3
   } state_e;

   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;
   localparam logic DIR_UP    = 1'b0;

   localparam int BAR_OBSTACLE = 0;
   localparam int BAR_PADDLE   = 1;

endpackage

// File: rtl/ball_tick_gen.sv
// Movement tick divider: counts enabled cycles
// and pulses on the last count; sync clear wins.
module ball_tick_gen #(
   parameter int DIV = 50000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // tick must not depend on clr_i: the clear is derived from it
   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ball_engine.sv
// Single-ball motion engine with serve/move/over FSM,
// lives, paddle speed-up and configurable bar role.
module ball_engine
   import ball_pkg::*;
#(
   parameter int COORD_W       = 10,
   parameter int SCREEN_W      = 640,
   parameter int SCREEN_H      = 480,
   parameter int BALL_SIZE     = 16,
   parameter int TICK_DIV      = 50000,
   parameter int INIT_X        = 140,
   parameter int INIT_Y        = 110,
   parameter int INIT_SPEED    = 2,
   parameter int MAX_SPEED     = 8,
   parameter int SPEEDUP_EVERY = 4,
   parameter int LIVES         = 3,
   parameter int SERVE_TICKS   = 500,
   parameter int BAR_MODE      = 1,
   parameter int BOTTOM_KILLS  = 1
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic               pause,
   input  logic [COORD_W-1:0] bar_leftLimit,
   input  logic [COORD_W-1:0] bar_rightLimit,
   input  logic [COORD_W-1:0] bar_topLimit,
   input  logic [COORD_W-1:0] bar_bottomLimit,
   output logic [COORD_W-1:0] ball_leftLimit,
   output logic [COORD_W-1:0] ball_rightLimit,
   output logic [COORD_W-1:0] ball_topLimit,
   output logic [COORD_W-1:0] ball_bottomLimit,
   output logic               ball_x_dir,
   output logic               ball_y_dir,
   output logic [3:0]         ball_speed,
   output logic [3:0]         lives_left,
   output logic [7:0]         hit_count,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic [1:0]         engine_state,
   output logic               game_over_flag
);

   localparam int W = COORD_W + 1;
   typedef logic [W-1:0] wide_t;
   typedef logic [COORD_W-1:0] crd_t;

   localparam wide_t XMAX = wide_t'(SCREEN_W - BALL_SIZE);
   localparam wide_t YMAX = wide_t'(SCREEN_H - BALL_SIZE);
   localparam wide_t BSZ  = wide_t'(BALL_SIZE);
   localparam crd_t  X0   = crd_t'(INIT_X);
   localparam crd_t  Y0   = crd_t'(INIT_Y);
   localparam crd_t  BEDGE = crd_t'(BALL_SIZE - 1);
   localparam logic [3:0] SPD0   = 4'(INIT_SPEED);
   localparam logic [3:0] SPDMAX = 4'(MAX_SPEED);
   localparam logic [3:0] LIVES0 = 4'(LIVES);
   localparam int STW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
   localparam logic [STW-1:0] SRV_LAST = STW'(SERVE_TICKS - 1);

   state_e         state_q, state_d;
   crd_t           x_q, x_d, y_q, y_d;
   logic           xdir_q, xdir_d, ydir_q, ydir_d;
   logic [3:0]     spd_q, spd_d;
   logic [3:0]     lives_q, lives_d;
   logic [7:0]     hits_q, hits_d;
   logic           hitp_q, hitp_d, missp_q, missp_d;
   logic [STW-1:0] srv_q, srv_d;

   logic tick, tick_en, tick_clr;

   ball_tick_gen #(
      .DIV(TICK_DIV)
   ) u_tick (
      .clk_i (CLOCK_50),
      .rst_ni(reset),
      .en_i  (tick_en),
      .clr_i (tick_clr),
      .tick_o(tick)
   );

   assign tick_en  = ((state_q == ST_SERVE) || (state_q == ST_MOVE)) && !pause;
   assign tick_clr = (state_d != state_q);

   wide_t      xw, yw, sw, mx, my, pad_y, bt_w;
   logic       mxdir, mydir, bot_hit, ov, paddle, miss, spd_step;
   logic [7:0] hits_inc;
   logic       unused_msb;

   always_comb begin
      xw    = {1'b0, x_q};
      yw    = {1'b0, y_q};
      sw    = wide_t'(spd_q);
      bt_w  = {1'b0, bar_topLimit};
      mx    = xw;
      my    = yw;
      mxdir = xdir_q;
      mydir = ydir_q;
      bot_hit = 1'b0;

      if (xdir_q == DIR_RIGHT) begin
         if (xw + sw >= XMAX) begin
            mx    = XMAX;
            mxdir = DIR_LEFT;
         end else begin
            mx = xw + sw;
         end
      end else if (xw < sw) begin
         mx    = '0;
         mxdir = DIR_RIGHT;
      end else begin
         mx = xw - sw;
      end

      if (ydir_q == DIR_DOWN) begin
         if (yw + sw >= YMAX) begin
            my      = YMAX;
            bot_hit = 1'b1;
            if (BOTTOM_KILLS == 0) mydir = DIR_UP;
         end else begin
            my = yw + sw;
         end
      end else if (yw < sw) begin
         my    = '0;
         mydir = DIR_DOWN;
      end else begin
         my = yw - sw;
      end

      // half-open overlap of the clamped ball against the bar
      ov = (mx < {1'b0, bar_rightLimit})
        && (mx + BSZ > {1'b0, bar_leftLimit})
        && (my < {1'b0, bar_bottomLimit})
        && (my + BSZ > bt_w);

      paddle = (BAR_MODE == BAR_PADDLE) && ov
            && (ydir_q == DIR_DOWN);
      pad_y  = (bt_w >= BSZ) ? bt_w - BSZ : '0;

      hits_inc = (hits_q == 8'hFF) ? hits_q
                                   : hits_q + 8'd1;
      spd_step = ((32'(hits_inc) % SPEEDUP_EVERY) == 0)
              && (spd_q < SPDMAX);

      miss = !paddle
          && ((bot_hit && (BOTTOM_KILLS != 0))
           || (ov && (BAR_MODE == BAR_OBSTACLE)));
   end

   assign unused_msb = ^{mx[W-1], my[W-1], pad_y[W-1]};

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      xdir_d  = xdir_q;
      ydir_d  = ydir_q;
      spd_d   = spd_q;
      lives_d = lives_q;
      hits_d  = hits_q;
      hitp_d  = 1'b0;
      missp_d = 1'b0;
      srv_d   = '0;

      unique case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               state_d = ST_SERVE;
               lives_d = LIVES0;
               hits_d  = '0;
            end
         end
         ST_SERVE: begin
            srv_d = srv_q;
            if (tick) begin
               srv_d = srv_q + STW'(1);
               if (srv_q == SRV_LAST) state_d = ST_MOVE;
            end
         end
         ST_MOVE: begin
            if (tick) begin
               x_d    = mx[COORD_W-1:0];
               y_d    = paddle ? pad_y[COORD_W-1:0]
                               : my[COORD_W-1:0];
               xdir_d = mxdir;
               ydir_d = paddle ? DIR_UP : mydir;
               if (paddle) begin
                  hitp_d = 1'b1;
                  hits_d = hits_inc;
                  if (spd_step) spd_d = spd_q + 4'd1;
               end
               if (miss) begin
                  missp_d = 1'b1;
                  lives_d = lives_q - 4'd1;
                  state_d = (lives_q == 4'd1) ? ST_OVER
                                              : ST_SERVE;
               end
            end
         end
         default: ;
      endcase

      // every entry into SERVE re-arms the ball at the serve point
      if (state_d == ST_SERVE && state_q != ST_SERVE) begin
         x_d    = X0;
         y_d    = Y0;
         xdir_d = DIR_RIGHT;
         ydir_d = DIR_DOWN;
         spd_d  = SPD0;
         srv_d  = '0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         x_q     <= X0;
         y_q     <= Y0;
         xdir_q  <= DIR_RIGHT;
         ydir_q  <= DIR_DOWN;
         spd_q   <= SPD0;
         lives_q <= LIVES0;
         hits_q  <= '0;
         hitp_q  <= 1'b0;
         missp_q <= 1'b0;
         srv_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         xdir_q  <= xdir_d;
         ydir_q  <= ydir_d;
         spd_q   <= spd_d;
         lives_q <= lives_d;
         hits_q  <= hits_d;
         hitp_q  <= hitp_d;
         missp_q <= missp_d;
         srv_q   <= srv_d;
      end
   end

   assign ball_leftLimit   = x_q;
   assign ball_rightLimit  = x_q + BEDGE;
   assign ball_topLimit    = y_q;
   assign ball_bottomLimit = y_q + BEDGE;
   assign ball_x_dir       = xdir_q;
   assign ball_y_dir       = ydir_q;
   assign ball_speed       = spd_q;
   assign lives_left       = lives_q;
   assign hit_count        = hits_q;
   assign hit_pulse        = hitp_q;
   assign miss_pulse       = missp_q;
   assign engine_state     = state_q;
   assign game_over_flag   = (state_q == ST_OVER);

endmodule

// File: tb/tb_ball_engine.sv
// Randomized bench for ball_engine: a paddle/bottom-kill
// instance and an obstacle/bottom-reflect instance vs a model.
module tb_ball_engine;

   localparam int TD = 4, STK = 2;
   localparam int SW = 640, SH = 480, BS = 16;
   localparam int IX = 140, IY = 110;
   localparam int ISP = 2, MSP = 8, SE = 4, LV = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic pause = 1'b0;
   logic [9:0] bl = '0, br = '0, bt = '0, bb = '0;

   logic [9:0] l [2], r [2], t [2], b [2];
   logic       xd [2], yd [2], hp [2], mp [2], go [2];
   logic [3:0] sp [2], lf [2];
   logic [7:0] hc [2];
   logic [1:0] es [2];

   int n_chk = 0;
   int n_err = 0;

   // model state, index 0 = paddle unit, 1 = obstacle unit
   int m_st [2], m_x [2], m_y [2], m_dx [2], m_dy [2];
   int m_sp [2], m_lv [2], m_hc [2], m_cnt [2], m_sv [2];
   bit m_hp [2], m_mp [2];
   bit paddle_mode [2] = '{1'b1, 1'b0};
   bit bot_kill [2]    = '{1'b1, 1'b0};

   always #5 clk = ~clk;

   ball_engine #(
      .TICK_DIV(TD), .SERVE_TICKS(STK),
      .BAR_MODE(1), .BOTTOM_KILLS(1)
   ) u_pad (
      .CLOCK_50(clk), .reset(rst_n),
      .start(start), .pause(pause),
      .bar_leftLimit(bl), .bar_rightLimit(br),
      .bar_topLimit(bt), .bar_bottomLimit(bb),
      .ball_leftLimit(l[0]), .ball_rightLimit(r[0]),
      .ball_topLimit(t[0]), .ball_bottomLimit(b[0]),
      .ball_x_dir(xd[0]), .ball_y_dir(yd[0]),
      .ball_speed(sp[0]), .lives_left(lf[0]),
      .hit_count(hc[0]), .hit_pulse(hp[0]),
      .miss_pulse(mp[0]), .engine_state(es[0]),
      .game_over_flag(go[0])
   );

   ball_engine #(
      .TICK_DIV(TD), .SERVE_TICKS(STK),
      .BAR_MODE(0), .BOTTOM_KILLS(0)
   ) u_obs (
      .CLOCK_50(clk), .reset(rst_n),
      .start(start), .pause(pause),
      .bar_leftLimit(bl), .bar_rightLimit(br),
      .bar_topLimit(bt), .bar_bottomLimit(bb),
      .ball_leftLimit(l[1]), .ball_rightLimit(r[1]),
      .ball_topLimit(t[1]), .ball_bottomLimit(b[1]),
      .ball_x_dir(xd[1]), .ball_y_dir(yd[1]),
      .ball_speed(sp[1]), .lives_left(lf[1]),
      .hit_count(hc[1]), .hit_pulse(hp[1]),
      .miss_pulse(mp[1]), .engine_state(es[1]),
      .game_over_flag(go[1])
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         if (n_err <= 25)
            $display("FAIL %s @%0t got %0h want %0h",
                     tag, $time, got, want);
      end
   endtask

   task automatic serve_pos(input int k);
      m_x[k] = IX; m_y[k] = IY;
      m_dx[k] = 1; m_dy[k] = 1;
      m_sp[k] = ISP; m_sv[k] = 0;
   endtask

   task automatic model_reset(input int k);
      serve_pos(k);
      m_st[k] = 0; m_lv[k] = LV; m_hc[k] = 0;
      m_hp[k] = 0; m_mp[k] = 0; m_cnt[k] = 0;
   endtask

   task automatic model_step(input int k);
      bit en, tk, bot, ov, hit, miss;
      int nst, nx, ny, ndx, ndy;
      int ibl, ibr, ibt, ibb;
      ibl = int'(bl); ibr = int'(br);
      ibt = int'(bt); ibb = int'(bb);
      en  = (m_st[k] == 1 || m_st[k] == 2) && !pause;
      tk  = en && (m_cnt[k] == TD - 1);
      nst = m_st[k];
      m_hp[k] = 0; m_mp[k] = 0;
      if (m_st[k] == 0 || m_st[k] == 3) begin
         if (start) begin
            nst = 1; m_lv[k] = LV; m_hc[k] = 0;
         end
      end else if (m_st[k] == 1) begin
         if (tk) begin
            m_sv[k]++;
            if (m_sv[k] == STK) nst = 2;
         end
      end else if (tk) begin
         nx = m_x[k] + m_dx[k] * m_sp[k];
         ndx = m_dx[k];
         if (nx < 0) begin
            nx = 0; ndx = 1;
         end else if (nx >= SW - BS) begin
            nx = SW - BS; ndx = -1;
         end
         ny = m_y[k] + m_dy[k] * m_sp[k];
         ndy = m_dy[k]; bot = 0;
         if (ny < 0) begin
            ny = 0; ndy = 1;
         end else if (ny >= SH - BS) begin
            ny = SH - BS; bot = 1;
            if (!bot_kill[k]) ndy = -1;
         end
         ov = (nx < ibr) && (nx + BS > ibl)
           && (ny < ibb) && (ny + BS > ibt);
         hit = paddle_mode[k] && ov && (m_dy[k] == 1);
         if (hit) begin
            ny = (ibt >= BS) ? ibt - BS : 0;
            ndy = -1;
            m_hp[k] = 1;
            if (m_hc[k] < 255) m_hc[k]++;
            if (m_hc[k] % SE == 0 && m_sp[k] < MSP)
               m_sp[k]++;
         end
         miss = !hit && ((bot && bot_kill[k])
                      || (ov && !paddle_mode[k]));
         m_x[k] = nx; m_y[k] = ny;
         m_dx[k] = ndx; m_dy[k] = ndy;
         if (miss) begin
            m_mp[k] = 1;
            m_lv[k]--;
            nst = (m_lv[k] == 0) ? 3 : 1;
         end
      end
      if (nst != m_st[k]) m_cnt[k] = 0;
      else if (en) m_cnt[k] = (m_cnt[k] + 1) % TD;
      if (nst == 1 && m_st[k] != 1) serve_pos(k);
      m_st[k] = nst;
   endtask

   function automatic logic [63:0] exp_pos(input int k);
      return {24'd0, 10'(m_x[k]), 10'(m_y[k]),
              10'(m_x[k] + BS - 1), 10'(m_y[k] + BS - 1)};
   endfunction

   function automatic logic [63:0] exp_st(input int k);
      return {41'd0, m_dx[k] == 1, m_dy[k] == 1,
              4'(m_sp[k]), 4'(m_lv[k]), 8'(m_hc[k]),
              m_hp[k], m_mp[k], 2'(m_st[k]), m_st[k] == 3};
   endfunction

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         chk(k == 0 ? "pad_pos" : "obs_pos",
             {24'd0, l[k], t[k], r[k], b[k]}, exp_pos(k));
         chk(k == 0 ? "pad_stat" : "obs_stat",
             {41'd0, xd[k], yd[k], sp[k], lf[k], hc[k],
              hp[k], mp[k], es[k], go[k]}, exp_st(k));
      end
   endtask

   task automatic cycle();
      for (int k = 0; k < 2; k++) model_step(k);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int n;
      int saved;
      model_reset(0);
      model_reset(1);
      repeat (2) @(negedge clk);
      compare_all();
      chk("rst_state", 64'(es[0]), 64'd0);
      chk("rst_left", 64'(l[0]), 64'd140);
      chk("rst_lives", 64'(lf[1]), 64'd3);
      rst_n = 1'b1;
      repeat (3) cycle();

      // first serve and first movement step
      start = 1'b1;
      cycle();
      start = 1'b0;
      chk("serve_state", 64'(es[0]), 64'd1);
      repeat (12) cycle();
      chk("first_left", 64'(l[0]), 64'd142);
      chk("first_top", 64'(t[0]), 64'd112);
      chk("first_right", 64'(r[0]), 64'd157);
      chk("first_state", 64'(es[0]), 64'd2);

      // full-width bar: paddle bounces, obstacle loses a life
      bl = 10'd0; br = 10'd640; bt = 10'd300; bb = 10'd320;
      n = 0;
      while (m_lv[1] == LV && n < 3000) begin
         cycle(); n++;
      end
      chk("obs_miss_seen", 64'(n < 3000), 64'd1);
      chk("obs_lives", 64'(lf[1]), 64'd2);
      chk("obs_state", 64'(es[1]), 64'd1);
      chk("obs_left", 64'(l[1]), 64'd140);
      chk("obs_top", 64'(t[1]), 64'd110);

      n = 0;
      while (m_hc[0] < 4 && n < 9000) begin
         cycle(); n++;
      end
      chk("hit4_seen", 64'(n < 9000), 64'd1);
      chk("hit4_speed", 64'(sp[0]), 64'd3);
      chk("hit4_top", 64'(t[0]), 64'd284);

      // held pause during MOVE
      repeat (3) cycle();
      saved = m_x[0];
      pause = 1'b1;
      repeat (20) cycle();
      pause = 1'b0;
      chk("pause_hold", 64'(l[0]), 64'(saved));

      // randomized segments
      for (int s = 0; s < 10; s++) begin
         case ($urandom_range(0, 2))
            0: begin
               bl = '0; br = '0; bt = '0; bb = '0;
            end
            1: begin
               bl = '0; br = 10'd640;
               bt = 10'($urandom_range(200, 440));
               bb = bt + 10'($urandom_range(8, 40));
            end
            default: begin
               bl = 10'($urandom_range(0, 500));
               br = bl + 10'($urandom_range(16, 200));
               bt = 10'($urandom_range(100, 440));
               bb = bt + 10'($urandom_range(4, 40));
            end
         endcase
         for (int c = 0; c < 1500; c++) begin
            pause = ($urandom_range(0, 19) == 0);
            start = ($urandom_range(0, 99) == 0);
            cycle();
         end
      end
      pause = 1'b0;
      start = 1'b0;

      // asynchronous reset in the middle of MOVE
      start = 1'b1;
      n = 0;
      while (m_st[0] != 2 && n < 200) begin
         cycle(); n++;
      end
      start = 1'b0;
      chk("pre_rst_move", 64'(es[0]), 64'd2);
      repeat (5) cycle();
      #3 rst_n = 1'b0;
      model_reset(0);
      model_reset(1);
      #1;
      compare_all();
      chk("async_state", 64'(es[0]), 64'd0);
      chk("async_top", 64'(t[0]), 64'd110);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) cycle();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
Parametrised successor to the single-ball motion block: one ball moving on a configurable playfield, with its own serve/play/game-over state machine, lives, and speed-up on paddle hits. A mode parameter sets the bar's role: obstacle (contact costs a life) or paddle (ball bounces). Sits between the bar controller and the VGA renderer/score logic; outputs ball limits in the same left/right/top/bottom form the renderer already consumes.

Parameters:
COORD_W, 10, coordinate width in bits
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
BALL_SIZE, 16, ball edge length in pixels
TICK_DIV, 50000, CLOCK_50 cycles per movement tick (1 kHz)
INIT_X / INIT_Y, 140 / 110, serve position (left/top)
INIT_SPEED, 2, pixels per tick on each axis after serve
MAX_SPEED, 8, speed ceiling on each axis
SPEEDUP_EVERY, 4, paddle hits per +1 speed step
LIVES, 3, lives per game (range 1..15)
SERVE_TICKS, 500, ticks the ball is held in SERVE before moving
BAR_MODE, 1, 0 = bar is obstacle, 1 = bar is paddle
BOTTOM_KILLS, 1, 1 = bottom wall costs a life, 0 = bottom wall reflects

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  level; starts a game from IDLE or OVER
pause  in  1  level; freezes the tick counter, position and serve timer
bar_leftLimit / bar_rightLimit / bar_topLimit / bar_bottomLimit  in  COORD_W each  bar rectangle; right/bottom exclusive
ball_leftLimit / ball_rightLimit / ball_topLimit / ball_bottomLimit  out  COORD_W each  ball rectangle; right = left+BALL_SIZE-1, bottom = top+BALL_SIZE-1
ball_x_dir / ball_y_dir  out  1 each  1 = right/down
ball_speed  out  4  current pixels per tick
lives_left  out  4  remaining lives
hit_count  out  8  paddle hits this game, saturates at 255
hit_pulse  out  1  one-cycle pulse on a paddle bounce
miss_pulse  out  1  one-cycle pulse on a life lost
engine_state  out  2  IDLE=0, SERVE=1, MOVE=2, OVER=3
game_over_flag  out  1  high in OVER

Behaviour:
- Reset (async, active-low): state IDLE; ball at (INIT_X, INIT_Y); dirs 1/1; speed INIT_SPEED; lives LIVES; hit_count 0; pulses 0; tick counter 0.
- Tick: counter 0..TICK_DIV-1; it advances only in SERVE/MOVE with pause=0 and clears on every state change. tick = 1 on the cycle the counter equals TICK_DIV-1.
- IDLE: ball held at init. When start=1, go to SERVE on the next edge.
- SERVE: ball at init, dirs 1/1, speed INIT_SPEED. After SERVE_TICKS ticks, go to MOVE.
- MOVE, on tick (registered; new position visible the cycle after tick):
  - X: moving left with x<speed → x=0 and flip dir. Moving right with x+speed ≥ SCREEN_W-BALL_SIZE → x=SCREEN_W-BALL_SIZE and flip dir. Otherwise x ± speed.
  - Y top: same rule as X, clamping to 0.
  - Y bottom: y+speed ≥ SCREEN_H-BALL_SIZE → clamp. If BOTTOM_KILLS=1 this is a miss; otherwise flip dir.
  - Overlap test uses the post-clamp rectangle against the bar (half-open on both axes).
    - BAR_MODE=0: overlap = miss.
    - BAR_MODE=1 with y_dir=1: y=bar_top-BALL_SIZE (0 if negative), y_dir=0, hit_pulse, hit_count+1. Speed +1 when the new hit_count is a multiple of SPEEDUP_EVERY, capped at MAX_SPEED.
  - Priority: paddle hit beats bottom miss in the same tick. Bottom miss beats obstacle contact; only one life is lost per tick.
  - Miss: miss_pulse and lives-1. If new lives=0 go to OVER, else go to SERVE.
  - All arithmetic in COORD_W+1 bits so nothing wraps.
- OVER: ball frozen, game_over_flag=1. start=1 → lives=LIVES, hit_count=0, go to SERVE.
- pause is ignored in IDLE/OVER. start is ignored in SERVE/MOVE.
- Reset mid-game: immediate return to the reset values; no pulses.

Decomposition:
- Shared package ball_pkg holds the state encoding (IDLE/SERVE/MOVE/OVER), direction constants (DIR_RIGHT/DIR_DOWN=1) and the BAR_MODE encodings.
- One sub-module, ball_tick_gen: parametrised divider with enable and sync clear, output tick.

Test Plan:
- TICK_DIV=4, SERVE_TICKS=2, start pulse: IDLE → SERVE; MOVE after 8 enabled cycles; first move gives left=142, top=112, right=157.
- Ball x=622, dir right, speed 2: next tick gives left=624, x_dir=0; the following tick gives 622.
- BAR_MODE=1, bar top=300, ball top=284 moving down, x overlapping: hit_pulse, top=284, y_dir=0. The 4th such hit gives ball_speed=3.
- BAR_MODE=0, ball steps into bar: miss_pulse, lives 3→2, state SERVE, ball at (140,110).
- LIVES=1, BOTTOM_KILLS=1, ball reaches top=464: game_over_flag=1, state OVER. start gives lives=1, SERVE.
- pause=1 during MOVE for 20 cycles: limits and tick counter unchanged. reset=0 mid-MOVE: outputs back to reset values asynchronously.
